// File: rtl/aes_pkg.sv
// Shared definitions for the ShiftRows datapath: mode encodings and
// per-block-width row rotation amounts.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_FWD  = 2'b00,
    MODE_INV  = 2'b01,
    MODE_PASS = 2'b10,
    MODE_RSVD = 2'b11
  } sr_mode_e;

  // Rijndael uses a wider rotation on rows 2 and 3 for 256-bit blocks.
  function automatic int row_off(input int nb, input int r);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows byte permutation (forward, inverse or pass-through).
// Byte k sits at bits [8k:8k+7] counted from the MSB; byte index = 4*col + row.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] data,
  input  logic [1:0]       mode,
  output logic [32*NB-1:0] result
);

  localparam int W = 32 * NB;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = W - 8 - 8 * (4 * c + r);
      localparam int SRC_FWD = W - 8 - 8 * (4 * ((c + row_off(NB, r)) % NB) + r);
      localparam int SRC_INV = W - 8 - 8 * (4 * ((c - row_off(NB, r) + NB) % NB) + r);

      assign result[DST +: 8] = (mode == MODE_FWD) ? data[SRC_FWD +: 8] :
                                (mode == MODE_INV) ? data[SRC_INV +: 8] :
                                                     data[DST +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows with valid/ready handshake and one or two register stages.
// The permutation sits ahead of stage 1; stage 2 is a plain skid-free copy.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*NB-1:0]   in_data,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err,
  output logic               busy
);

  localparam int W = 32 * NB;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1 or 2");
  end

  logic [W-1:0]     perm_data;
  logic             s1_valid;
  logic             s1_err;
  logic             s1_drain;
  logic [W-1:0]     s1_data;
  logic [TAG_W-1:0] s1_tag;

  shift_rows_perm #(.NB(NB)) u_perm (
    .data   (in_data),
    .mode   (in_mode),
    .result (perm_data)
  );

  // Depends only on registered state and out_ready, never on in_valid.
  assign in_ready = !s1_valid || s1_drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= perm_data;
        s1_tag  <= in_tag;
        s1_err  <= (in_mode == MODE_RSVD);
      end
    end
  end

  if (STAGES == 1) begin : g_one
    assign s1_drain  = s1_valid && out_ready;
    assign out_valid = s1_valid;
    assign out_data  = s1_data;
    assign out_tag   = s1_tag;
    assign out_err   = s1_valid && s1_err;
    assign busy      = s1_valid;
  end else begin : g_two
    logic             s2_valid;
    logic             s2_err;
    logic             s2_ready;
    logic [W-1:0]     s2_data;
    logic [TAG_W-1:0] s2_tag;

    assign s2_ready = !s2_valid || out_ready;
    assign s1_drain = s1_valid && s2_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_err   <= 1'b0;
        s2_data  <= '0;
        s2_tag   <= '0;
      end else if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
          s2_tag  <= s1_tag;
          s2_err  <= s1_err;
        end
      end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_tag   = s2_tag;
    assign out_err   = s2_valid && s2_err;
    assign busy      = s1_valid || s2_valid;
  end

endmodule
